// File: rtl/sm_diff_serial.sv
// sm_diff_serial: bit-serial sign-magnitude add/subtract core.
// Latches two sign-magnitude operands and an op, then produces A+B (effective add)
// or A-B / B-A (effective sub) one bit per clock, LSB first, over W cycles.
// Optional macro SMD_DONE_HOLD_EN: done stays high from DONE until the next accepted start.
module sm_diff_serial #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         a_sign,
    input  logic         b_sign,
    input  logic         op,
    input  logic [W-1:0] mag_a,
    input  logic [W-1:0] mag_b,
    output logic [W-1:0] ffAB,
    output logic [W-1:0] ffBA,
    output logic         Cin,
    output logic         a,
    output logic         b,
    output logic         choose,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [W-1:0]    r_sa;
    logic [W-1:0]    r_sb;
    logic [W-1:0]    r_ab;
    logic [W-1:0]    r_ba;
    logic [CntW-1:0] r_cnt;
    logic            r_carry;
    logic            r_bab;
    logic            r_bba;
    logic            r_eff;
    logic            r_cin;
    logic            r_a;
    logic            r_b;
    logic            r_choose;
    logic            r_done;

    logic w_accept;
    logic w_last;
    logic w_xa;
    logic w_xb;
    logic w_sum;
    logic w_cout;
    logic w_dab;
    logic w_bab_n;
    logic w_dba;
    logic w_bba_n;

    assign w_accept = (r_state == StIdle) && start;
    assign w_last   = (r_state == StRun) && (r_cnt == CntW'(W - 1));
    assign w_xa     = r_sa[0];
    assign w_xb     = r_sb[0];

    // One full adder and two full subtractors shared across all bit positions.
    assign w_sum   = w_xa ^ w_xb ^ r_carry;
    assign w_cout  = (w_xa & w_xb) | (r_carry & (w_xa ^ w_xb));
    assign w_dab   = w_xa ^ w_xb ^ r_bab;
    assign w_bab_n = (~w_xa & w_xb) | (~(w_xa ^ w_xb) & r_bab);
    assign w_dba   = w_xa ^ w_xb ^ r_bba;
    assign w_bba_n = (~w_xb & w_xa) | (~(w_xa ^ w_xb) & r_bba);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for W cycles -> DONE for one cycle -> IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Operand latch, serial datapath and result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_ab     <= '0;
            r_ba     <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_bab    <= 1'b0;
            r_bba    <= 1'b0;
            r_eff    <= 1'b0;
            r_cin    <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_choose <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= mag_a;
            r_sb     <= mag_b;
            r_a      <= a_sign;
            r_b      <= b_sign;
            r_choose <= op;
            r_eff    <= op ^ a_sign ^ b_sign;
            r_carry  <= 1'b0;
            r_bab    <= 1'b0;
            r_bba    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (r_state == StRun) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_ab    <= {(r_eff ? w_dab : w_sum), r_ab[W-1:1]};
            r_ba    <= {(r_eff ? w_dba : w_sum), r_ba[W-1:1]};
            r_carry <= w_cout;
            r_bab   <= w_bab_n;
            r_bba   <= w_bba_n;
            r_cnt   <= r_cnt + CntW'(1);
            if (w_last) begin
                r_cin  <= r_eff ? w_bab_n : w_cout;
                r_done <= 1'b1;
            end
        end else if (r_state == StDone) begin
`ifdef SMD_DONE_HOLD_EN
            r_done <= 1'b1;
`else
            r_done <= 1'b0;
`endif
        end
    end

    assign ffAB   = r_ab;
    assign ffBA   = r_ba;
    assign Cin    = r_cin;
    assign a      = r_a;
    assign b      = r_b;
    assign choose = r_choose;
    assign busy   = (r_state != StIdle);
    assign done   = r_done;

endmodule

// File: doc/sm_diff_serial.md
Name: sm_diff_serial

Overview:
- Bit-serial producer of the magnitude results consumed by the sign-magnitude result selector of the LAB3 add/subtract datapath.
- Latches two sign-magnitude operands and an add/subtract request, then computes ffAB and ffBA one bit per clock, LSB first.
- Also produces the carry/borrow flag (Cin) and registered copies of the signs and the operation for the selector.
- Trades latency for area: one full adder and two full subtractors, reused over W cycles.

Parameters:
- W, 8, magnitude width in bits (≥2); the selector uses W=8.

Ports:
- clk  in  1  single clock; all flops rise-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE.
- a_sign  in  1  sign of A (1 = negative).
- b_sign  in  1  sign of B.
- op  in  1  0 = A+B, 1 = A−B.
- mag_a  in  W  magnitude of A.
- mag_b  in  W  magnitude of B.
- ffAB  out  W  A+B (effective add) or A−B mod 2^W (effective sub).
- ffBA  out  W  A+B (effective add) or B−A mod 2^W (effective sub).
- Cin  out  1  effective add: carry out of A+B; effective sub: borrow of A−B (1 iff A<B).
- a  out  1  latched a_sign.
- b  out  1  latched b_sign.
- choose  out  1  latched op.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results valid.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. ffAB, ffBA, Cin, a, b, choose, busy and done all 0. Shift registers and bit counter cleared. Reset wins over every other input in the same cycle, including mid-RUN; a partial result is discarded, never reported.
- eff_sub = op ^ a_sign ^ b_sign, latched at accept.
- FSM:
  - IDLE: if start, latch mag_a, mag_b, signs, op and eff_sub. Clear carry = 0, borrowAB = 0, borrowBA = 0, cnt = 0. Go to RUN. Otherwise hold all outputs.
  - RUN: each cycle, take bit cnt of A and B (shift right).
    - Full-add sum bit, or subtract bit A−B via borrowAB, shifted into ffAB MSB-side.
    - Same for ffBA, using the sum bit or the B−A bit via borrowBA.
    - Update carry/borrows; cnt++.
    - When cnt == W−1 completes: go to DONE.
    - Set Cin = eff_sub ? final borrowAB : final carry.
  - DONE: done = 1 for exactly one cycle; go to IDLE.
- ffAB and ffBA change only during RUN. They are stable from the DONE cycle until the next accepted start.
- a, b and choose update on accept and hold until the next accept.
- Latency: start sampled at edge k → done high in the cycle after edge k+W (W+1 cycles from start).
- start while busy: ignored; no queueing.
- start held high through DONE: re-accepted on the first IDLE cycle, giving back-to-back ops every W+2 cycles.
- Wrap-around: subtraction results are modulo 2^W. Equal magnitudes give ffAB = ffBA = 0 and Cin = 0.
- Operands on mag_a/mag_b may change freely after accept.

Optional Feature:
- Macro: SMD_DONE_HOLD_EN.
- Defined: done stays high from DONE until the next accepted start (level "result valid"). The FSM still returns to IDLE after one DONE cycle, so busy drops after one cycle exactly as without the macro. A reset clears done.
- Undefined: done is a one-cycle pulse as above.
- All other timing is identical in both builds.

Test Plan:
- reset held 2 cycles, then released → all outputs 0, busy = 0. Reset asserted at RUN cycle 3 → next cycle IDLE, all outputs 0, no done.
- W=8, mag_a=0x25, mag_b=0x10, signs 0/0, op=1 → done at start+9: ffAB=0x15, ffBA=0xEB, Cin=0, choose=1.
- mag_a=0x10, mag_b=0x25, a_sign=0, b_sign=1, op=0 (eff_sub) → ffAB=0xEB, ffBA=0x15, Cin=1, a=0, b=1.
- mag_a=0xF0, mag_b=0x20, signs 0/0, op=0 → ffAB=ffBA=0x10, Cin=1 (carry). mag_a=mag_b=0x7F, op=1 → ffAB=ffBA=0x00, Cin=0.
- start pulsed during RUN with different operands → ignored; results match the first op. start held high continuously → accepts spaced exactly W+2 = 10 cycles.
- Build with SMD_DONE_HOLD_EN defined: done stays 1 after completion until next start, busy drops after one cycle. Without the macro: done is exactly 1 cycle.
